// File: rtl/anc_fir.sv
// ============================================================================
//  Module   : anc_fir
//  Purpose  : Sequential-MAC FIR estimator for adaptive noise cancellation.
//             Produces Yn = sum(Wn[k]*Rn[n-k]) in Q1.23 and AncEn = Dn - Yn.
//  Options  : define ANC_FIR_SAT_EN to saturate Yn/AncEn instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module anc_fir #(
  parameter int W1   = 24,
  parameter int TAPS = 8,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sample_valid,
  input  logic signed [W1-1:0] Rn,
  input  logic signed [W1-1:0] Dn,
  output logic        [AW-1:0] coef_addr,
  input  logic signed [W1-1:0] coef_data,
  output logic                 busy,
  output logic signed [W1-1:0] Yn,
  output logic signed [W1-1:0] AncEn,
  output logic                 out_valid
);

  localparam int PW   = 2 * W1;
  localparam int ACCW = 2 * W1 + AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic        [AW-1:0]  r_cnt;
  logic signed [W1-1:0]  r_tap [TAPS];
  logic signed [W1-1:0]  r_dn;
  logic signed [ACCW-1:0] r_acc;
  logic                  r_add_pend;
  logic        [AW-1:0]  r_add_k;
  logic signed [W1-1:0]  r_yn;
  logic signed [W1-1:0]  r_ancen;
  logic                  r_out_valid;
  logic                  r_stall;
  logic signed [W1-1:0]  r_coef_hold;

  logic signed [W1-1:0]  w_coef;
  logic signed [PW-1:0]  w_prod;
  logic signed [W1-1:0]  w_y;
  logic        [W1:0]    w_e_full;
  logic signed [W1-1:0]  w_e;
  logic                  w_unused;

  // The coefficient for an address arrives one clock later even while en is
  // low, so the first stalled cycle captures it for use when en returns.
  assign w_coef   = r_stall ? r_coef_hold : coef_data;
  assign w_prod   = PW'(w_coef) * PW'(r_tap[r_add_k]);
  assign w_e_full = {r_dn[W1-1], r_dn} - {w_y[W1-1], w_y};

`ifdef ANC_FIR_SAT_EN
  localparam logic signed [W1-1:0] c_sat_max = {1'b0, {(W1-1){1'b1}}};
  localparam logic signed [W1-1:0] c_sat_min = {1'b1, {(W1-1){1'b0}}};

  logic w_y_ovf;
  logic w_e_ovf;

  assign w_y_ovf  = ~((&r_acc[ACCW-1:PW-2]) | ~(|r_acc[ACCW-1:PW-2]));
  assign w_e_ovf  = w_e_full[W1] ^ w_e_full[W1-1];
  assign w_y      = w_y_ovf ? (r_acc[ACCW-1] ? c_sat_min : c_sat_max)
                            : r_acc[PW-2:W1-1];
  assign w_e      = w_e_ovf ? (w_e_full[W1] ? c_sat_min : c_sat_max)
                            : w_e_full[W1-1:0];
  assign w_unused = ^{r_acc[W1-2:0]};
`else
  assign w_y      = r_acc[PW-2:W1-1];
  assign w_e      = w_e_full[W1-1:0];
  assign w_unused = ^{r_acc[ACCW-1:PW-1], r_acc[W1-2:0], w_e_full[W1]};
`endif

  assign coef_addr = (r_state == MAC) ? r_cnt : '0;
  assign busy      = (r_state != IDLE);
  assign Yn        = r_yn;
  assign AncEn     = r_ancen;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall     <= 1'b0;
      r_coef_hold <= '0;
    end else begin
      r_stall <= ~en;
      if (!en && !r_stall) r_coef_hold <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dn        <= '0;
      r_acc       <= '0;
      r_add_pend  <= 1'b0;
      r_add_k     <= '0;
      r_yn        <= '0;
      r_ancen     <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) r_tap[k] <= '0;
    end else if (en) begin
      r_out_valid <= 1'b0;
      r_add_pend  <= 1'b0;
      if (r_add_pend) r_acc <= r_acc + ACCW'(w_prod);
      case (r_state)
        IDLE: begin
          if (sample_valid) begin
            for (int k = TAPS - 1; k > 0; k--) r_tap[k] <= r_tap[k-1];
            r_tap[0] <= Rn;
            r_dn     <= Dn;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= MAC;
          end
        end
        MAC: begin
          r_add_pend <= 1'b1;
          r_add_k    <= r_cnt;
          if (r_cnt == AW'(TAPS - 1)) begin
            r_cnt   <= '0;
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        DRAIN: r_state <= DONE;
        DONE: begin
          r_yn        <= w_y;
          r_ancen     <= w_e;
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_anc_fir.sv
// ============================================================================
//  Module   : tb_anc_fir
//  Purpose  : Scoreboard bench for anc_fir (honours ANC_FIR_SAT_EN in its model).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_anc_fir;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        sample_valid;
  logic [23:0] Rn;
  logic [23:0] Dn;
  logic [2:0]  coef_addr;
  logic [23:0] coef_data;
  logic        busy;
  logic [23:0] Yn;
  logic [23:0] AncEn;
  logic        out_valid;

  anc_fir #(.W1(24), .TAPS(8), .AW(3)) u_dut (
    .clk(clk), .reset(reset), .en(en), .sample_valid(sample_valid),
    .Rn(Rn), .Dn(Dn), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .Yn(Yn), .AncEn(AncEn), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  logic signed [23:0] coef_mem [8];
  always @(posedge clk) coef_data <= coef_mem[coef_addr];

  typedef struct {
    logic [23:0] y;
    logic [23:0] e;
    int          lat;
  } exp_t;

  exp_t   sb[$];
  longint hist[8];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] clamp24(input longint v);
    logic [23:0] r;
`ifdef ANC_FIR_SAT_EN
    if (v > 64'sd8388607)       r = 24'h7FFFFF;
    else if (v < -64'sd8388608) r = 24'h800000;
    else                        r = v[23:0];
`else
    r = v[23:0];
`endif
    return r;
  endfunction

  // Reference model: shift history, full-precision dot product, rescale.
  task automatic model_push(input logic [23:0] rn, input logic [23:0] dn, input int lat);
    exp_t   x;
    longint acc;
    longint ys;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'($signed(rn));
    acc = 0;
    for (int k = 0; k < 8; k++) acc += hist[k] * longint'(coef_mem[k]);
    x.y   = clamp24(acc >>> 23);
    ys    = longint'($signed(x.y));
    x.e   = clamp24(longint'($signed(dn)) - ys);
    x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic send(input logic [23:0] rn, input logic [23:0] dn,
                      input int stall_at, input bit pulse_sv, input string tag);
    exp_t        g;
    int          c;
    bit          seen;
    logic [23:0] y_hold;
    @(negedge clk);
    en = 1'b1; Rn = rn; Dn = dn; sample_valid = 1'b1;
    model_push(rn, dn, (stall_at > 0) ? 14 : 11);
    @(negedge clk);
    sample_valid = 1'b0; Rn = 24'h7ABCDE;
    c = 1; seen = 1'b0;
    while (c <= 40 && !seen) begin
      if (out_valid) seen = 1'b1;
      else begin
        if (c == 3 && stall_at == 0) check_eq({tag, "_addr"}, coef_addr, 2);
        en = !(stall_at > 0 && c >= stall_at && c < stall_at + 3);
        sample_valid = pulse_sv && (c == 4);
        if (sample_valid) Rn = 24'h654321;
        @(negedge clk);
        c++;
      end
    end
    en = 1'b1; sample_valid = 1'b0;
    if (!seen) begin
      check_eq({tag, "_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 0, 1);
    end else begin
      g = sb.pop_front();
      check_eq({tag, "_y"},   Yn, g.y);
      check_eq({tag, "_e"},   AncEn, g.e);
      check_eq({tag, "_lat"}, c, g.lat);
      check_eq({tag, "_busy"}, busy, 0);
      y_hold = g.y;
      @(negedge clk);
      check_eq({tag, "_pulse"}, out_valid, 0);
      check_eq({tag, "_yhold"}, Yn, y_hold);
    end
  endtask

  task automatic set_coefs(input logic [23:0] v);
    for (int k = 0; k < 8; k++) coef_mem[k] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    reset = 1'b0; en = 1'b1; sample_valid = 1'b0; Rn = '0; Dn = '0;
    set_coefs(24'h0);
    for (int k = 0; k < 8; k++) hist[k] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_y", Yn, 0);
    check_eq("rst_e", AncEn, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr", coef_addr, 0);
    reset = 1'b1;

    send(24'h300000, 24'h100000, 0, 1'b0, "zero_coef");
    check_eq("zero_coef_e_const", AncEn, 24'h100000);

    coef_mem[0] = 24'h400000;
    send(24'h200000, 24'h300000, 0, 1'b0, "single_tap");
    check_eq("single_tap_y_const", Yn, 24'h100000);
    check_eq("single_tap_e_const", AncEn, 24'h200000);

    // Abort mid-MAC with reset; history must come back empty.
    set_coefs(24'h400000);
    @(negedge clk);
    Rn = 24'h111111; Dn = 24'h222222; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("abort_y", Yn, 0);
    check_eq("abort_e", AncEn, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_addr", coef_addr, 0);
    check_eq("abort_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check_eq("abort_no_valid", saw_valid, 0);
    send(24'h000000, 24'h000123, 0, 1'b0, "post_reset");

    set_coefs(24'h0);
    coef_mem[2] = 24'h400000;
    send(24'h200000, 24'h000010, 0, 1'b0, "dly0");
    send(24'h000000, 24'h000020, 0, 1'b0, "dly1");
    send(24'h000000, 24'h000030, 0, 1'b0, "dly2");
    check_eq("dly2_y_const", Yn, 24'h100000);

    for (int k = 0; k < 8; k++) coef_mem[k] = 24'($urandom);
    for (int i = 0; i < 6; i++)
      send(24'($urandom), 24'($urandom), 0, 1'b0, "rand");
    send(24'h0A0B0C, 24'h123456, 0, 1'b1, "sv_ignored");
    send(24'h7F0001, 24'hF00000, 3, 1'b0, "en_stall");
    send(24'h00F00F, 24'h000001, 0, 1'b0, "after_hs");

    set_coefs(24'h7FFFFF);
    for (int i = 0; i < 8; i++)
      send(24'h7FFFFF, 24'h800000, 0, 1'b0, "sat");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
